multicycle_ctrl: RTL and testbench

//   Multicycle control FSM for the RV32 datapath. It drives PCSrc, ALUSrc, RegWrite,

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Five-cycle (IF/ID/EX/MEM/WB) control FSM for the RV32 datapath.
// Drives datapath selects and strobes, counts retired instructions, halts on illegal opcodes.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IF   | fetch; selects at reset values
//   S_ID   | decode; illegal instruction branches to S_HALT
//   S_EX   | ALU operates; branch outcome captured into taken_q
//   S_MEM  | data memory access (MemRead for LOAD, MemWrite for STORE)
//   S_WB   | register write-back, PC update, instret increment
//   S_HALT | parked after an illegal instruction; left only by reset
module multicycle_ctrl #(
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SLT = 4'b0100,
  parameter logic [3:0] ALU_XOR = 4'b0101,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_SRL = 4'b1000,
  parameter logic [3:0] ALU_SLL = 4'b1001,
  parameter logic [3:0] ALU_SRA = 4'b1010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        halted,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  state_t state_q, state_d;
  logic   taken_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b;
  logic [4:0] rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b    = instr[30];
  assign rd     = instr[11:7];

  logic [3:0] dec_alu;
  logic       dec_alusrc, dec_illegal, br_cond;
  logic       is_r, is_i, is_load, is_store, is_branch;

  always_comb begin
    dec_alu     = ALU_ADD;
    dec_alusrc  = 1'b0;
    dec_illegal = 1'b0;
    br_cond     = 1'b0;
    is_r        = 1'b0;
    is_i        = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        is_r       = (opcode == OP_R);
        is_i       = (opcode == OP_I);
        dec_alusrc = is_i;
        case (funct3)
          3'b000:  dec_alu = (is_r && f7b) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_alu = ALU_SLL;
          3'b010:  dec_alu = ALU_SLT;
          3'b100:  dec_alu = ALU_XOR;
          3'b101:  dec_alu = f7b ? ALU_SRA : ALU_SRL;
          3'b110:  dec_alu = ALU_OR;
          3'b111:  dec_alu = ALU_AND;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        is_load     = (opcode == OP_LOAD);
        is_store    = (opcode == OP_STORE);
        dec_alusrc  = 1'b1;
        dec_illegal = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        dec_alu   = ALU_SUB;
        case (funct3)
          3'b000:  br_cond = Zero;
          3'b001:  br_cond = ~Zero;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal encodings present neutral selects so nothing downstream acts on them.
    if (dec_illegal) begin
      dec_alu    = ALU_ADD;
      dec_alusrc = 1'b0;
      is_r       = 1'b0;
      is_i       = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_branch  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      taken_q <= 1'b0;
      instret <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EX)
        taken_q <= is_branch & br_cond;
      if (state_q == S_WB)
        instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    PCSrc    = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    ALUCtrl  = ALU_ADD;
    loadPC   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        ALUSrc  = dec_alusrc;
        ALUCtrl = dec_alu;
        state_d = dec_illegal ? S_HALT : S_EX;
      end
      S_EX: begin
        ALUSrc  = dec_alusrc;
        ALUCtrl = dec_alu;
        state_d = S_MEM;
      end
      S_MEM: begin
        ALUSrc   = dec_alusrc;
        ALUCtrl  = dec_alu;
        MemRead  = is_load;
        MemWrite = is_store;
        state_d  = S_WB;
      end
      S_WB: begin
        ALUSrc   = dec_alusrc;
        ALUCtrl  = dec_alu;
        loadPC   = 1'b1;
        PCSrc    = taken_q;
        RegWrite = (is_r | is_i | is_load) & (rd != 5'd0);
        MemToReg = is_load;
        MemRead  = is_load;
        state_d  = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected outputs,
// a monitor pops and compares one entry at every falling clock edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic        pcsrc;
    logic        alusrc;
    logic        regwrite;
    logic        memtoreg;
    logic [3:0]  aluctrl;
    logic        loadpc;
    logic        memread;
    logic        memwrite;
    logic        halted;
    logic [31:0] instret;
  } out_t;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SLT = 4'b0100, A_XOR = 4'b0101, A_SUB = 4'b0110,
                         A_SRA = 4'b1010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, halted;
  logic [3:0]  ALUCtrl;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  out_t  exp_q[$];
  string tag_q[$];
  int    cyc_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] n_ret = 32'd0;

  function automatic out_t idle_exp(input logic [31:0] ret);
    out_t e;
    e = '0;
    e.aluctrl = A_ADD;
    e.instret = ret;
    return e;
  endfunction

  task automatic push(input string nm, input int c, input out_t e);
    exp_q.push_back(e);
    tag_q.push_back(nm);
    cyc_q.push_back(c);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0;
    push(nm, 0, idle_exp(32'd0));
    @(posedge clk); #1;
    rst = 1'b1;
    n_ret = 32'd0;
  endtask

  // One instruction from IF; ncyc<5 stops early so a reset can interrupt it.
  task automatic issue(input string nm, input logic [31:0] ins, input logic [3:0] alu,
                       input logic asrc, input logic rw, input logic ld, input logic st,
                       input logic pcs, input logic zex, input int ncyc);
    out_t e;
    instr = ins;
    Zero  = ~zex;
    for (int c = 0; c < ncyc; c++) begin
      e = idle_exp(n_ret);
      if (c >= 1) begin
        e.aluctrl = alu;
        e.alusrc  = asrc;
      end
      if (c == 3) begin
        e.memread  = ld;
        e.memwrite = st;
      end
      if (c == 4) begin
        e.loadpc   = 1'b1;
        e.pcsrc    = pcs;
        e.regwrite = rw;
        e.memtoreg = ld;
        e.memread  = ld;
      end
      push(nm, c, e);
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 1) Zero = zex;
      if (c == 2) Zero = ~zex;
    end
    if (ncyc == 5) n_ret = n_ret + 32'd1;
  endtask

  task automatic issue_illegal(input string nm, input logic [31:0] ins, input int nh);
    out_t e;
    instr = ins;
    push(nm, 0, idle_exp(n_ret));
    push(nm, 1, idle_exp(n_ret));
    for (int c = 0; c < nh; c++) begin
      e = idle_exp(n_ret);
      e.halted = 1'b1;
      push(nm, 2 + c, e);
    end
    for (int c = 0; c < 2 + nh; c++) begin
      @(posedge clk); #1;
      Zero = ~Zero;
    end
  endtask

  initial begin
    out_t e, a;
    string t;
    int c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        c = cyc_q.pop_front();
        a = {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite,
             halted, instret};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s cycle %0d: got pcs=%b asrc=%b rw=%b m2r=%b alu=%b lpc=%b mr=%b mw=%b h=%b ret=%0d required pcs=%b asrc=%b rw=%b m2r=%b alu=%b lpc=%b mr=%b mw=%b h=%b ret=%0d",
                   t, c, a.pcsrc, a.alusrc, a.regwrite, a.memtoreg, a.aluctrl, a.loadpc,
                   a.memread, a.memwrite, a.halted, a.instret,
                   e.pcsrc, e.alusrc, e.regwrite, e.memtoreg, e.aluctrl, e.loadpc,
                   e.memread, e.memwrite, e.halted, e.instret);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b0;
    instr = 32'h0000_0013;
    Zero  = 1'b0;
    @(posedge clk); #1;
    do_reset("reset");
    //     name      instr          alu    asrc rw ld st pcs zex ncyc
    issue("addi",  32'h00500093, A_ADD, 1, 1, 0, 0, 0, 0, 5);
    issue("add",   32'h002081B3, A_ADD, 0, 1, 0, 0, 0, 0, 5);
    issue("sub",   32'h402081B3, A_SUB, 0, 1, 0, 0, 0, 0, 5);
    issue("lw",    32'h0080A283, A_ADD, 1, 1, 1, 0, 0, 0, 5);
    issue("sw",    32'h0050A223, A_ADD, 1, 0, 0, 1, 0, 0, 5);
    issue("beq_t", 32'h00000463, A_SUB, 0, 0, 0, 0, 1, 1, 5);
    issue("bne_n", 32'h00001463, A_SUB, 0, 0, 0, 0, 0, 1, 5);
    issue("bne_t", 32'h00001463, A_SUB, 0, 0, 0, 0, 1, 0, 5);
    issue("beq_n", 32'h00000463, A_SUB, 0, 0, 0, 0, 0, 0, 5);
    issue("srai",  32'h40325213, A_SRA, 1, 1, 0, 0, 0, 0, 5);
    issue("nop",   32'h00000013, A_ADD, 1, 0, 0, 0, 0, 0, 5);
    issue("xor",   32'h0020C1B3, A_XOR, 0, 1, 0, 0, 0, 0, 5);
    issue("slti",  32'h00002093, A_SLT, 1, 1, 0, 0, 0, 0, 5);
    issue("or",    32'h0020E1B3, A_OR,  0, 1, 0, 0, 0, 0, 5);
    issue("andi",  32'h0FF0F093, A_AND, 1, 1, 0, 0, 0, 0, 5);
    issue_illegal("op7f", 32'h0000007F, 4);
    do_reset("reset_halt");
    issue("addi2", 32'h00500093, A_ADD, 1, 1, 0, 0, 0, 0, 5);
    issue("lw_ab", 32'h0080A283, A_ADD, 1, 1, 1, 0, 0, 0, 3);
    do_reset("reset_mid");
    issue("sw2",   32'h0050A223, A_ADD, 1, 0, 0, 1, 0, 0, 5);
    issue_illegal("lb_ill", 32'h00808283, 3);
    do_reset("reset_end");
    issue("add2",  32'h002081B3, A_ADD, 0, 1, 0, 0, 0, 0, 5);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
